// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared types for the rotate arbiter
package rotate_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/multi_barrel_shifter_reverser.sv
// rtl/multi_barrel_shifter_reverser.sv - combinational rotator, lr=1 left / lr=0 right
// Left rotation is a right rotation framed by two bit reversals.
module multi_barrel_shifter_reverser #(
  parameter int N = 3,
  localparam int W = 1 << N
) (
  input  logic [W-1:0] a,
  input  logic [N-1:0] amt,
  input  logic         lr,
  output logic [W-1:0] y
);

  logic [W-1:0] a_in;
  logic [W-1:0] stage;

  always_comb begin
    a_in  = '0;
    stage = '0;
    y     = '0;
    for (int i = 0; i < W; i++) begin
      a_in[i] = lr ? a[W-1-i] : a[i];
    end
    stage = a_in;
    for (int s = 0; s < N; s++) begin
      if (amt[s]) begin
        stage = (stage >> (1 << s)) | (stage << (W - (1 << s)));
      end
    end
    for (int i = 0; i < W; i++) begin
      y[i] = lr ? stage[W-1-i] : stage[i];
    end
  end

endmodule

// File: rtl/rotate_arbiter.sv
// rtl/rotate_arbiter.sv - two-requester round-robin front end to one shared rotator
// One registered result slot; a new request may be accepted in the cycle the held one drains.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int N = 3,
  localparam int W = 1 << N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic [N-1:0] req0_amt,
  input  logic         req0_lr,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  input  logic [N-1:0] req1_amt,
  input  logic         req1_lr,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id
);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [W-1:0] data_q, data_d;
  logic         id_q, id_d;

  logic         grant;
  logic         can_accept;
  logic         xfer;
  logic [W-1:0] sel_data;
  logic [N-1:0] sel_amt;
  logic         sel_lr;
  logic [W-1:0] rot_y;

  // ptr_q names the requester that wins the next contention.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ptr_q : (req1_valid && !req0_valid);
    can_accept = !reset && ((state_q == IDLE) || rsp_ready);
    req0_ready = can_accept && !grant;
    req1_ready = can_accept && grant;
    sel_data   = grant ? req1_data : req0_data;
    sel_amt    = grant ? req1_amt  : req0_amt;
    sel_lr     = grant ? req1_lr   : req0_lr;
  end

  multi_barrel_shifter_reverser #(.N(N)) u_rot (
    .a   (sel_data),
    .amt (sel_amt),
    .lr  (sel_lr),
    .y   (rot_y)
  );

  always_comb begin
    xfer    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (xfer) begin
      state_d = HOLD;
      data_d  = rot_y;
      id_d    = grant;
      ptr_d   = !grant;
    end else if ((state_q == HOLD) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// tb/tb_rotate_arbiter.sv - table-driven and scoreboard bench for rotate_arbiter
module tb_rotate_arbiter;

  localparam int N = 3;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_lr;
  logic [W-1:0] req0_data;
  logic [N-1:0] req0_amt;
  logic         req1_valid, req1_ready, req1_lr;
  logic [W-1:0] req1_data;
  logic [N-1:0] req1_amt;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;

  always #5 clk = ~clk;

  rotate_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_lr    (req0_lr),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_lr    (req1_lr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  typedef struct {
    logic         rst;
    logic         v0;
    logic [W-1:0] d0;
    logic [N-1:0] a0;
    logic         l0;
    logic         v1;
    logic [W-1:0] d1;
    logic [N-1:0] a1;
    logic         l1;
    logic         rr;
    logic         chk;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_id;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         id;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic m_hold = 1'b0;
  logic m_ptr  = 1'b0;

  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input logic [N-1:0] k,
                                           input logic left);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < int'(k); i++) begin
      r = left ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [W-1:0] d0,
                     input logic [N-1:0] a0, input logic l0, input logic v1,
                     input logic [W-1:0] d1, input logic [N-1:0] a1, input logic l1,
                     input logic rr, input logic chk, input logic ev,
                     input logic [W-1:0] ed, input logic eid);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.a0 = a0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.a1 = a1; v.l1 = l1; v.rr = rr;
    v.chk = chk; v.exp_valid = ev; v.exp_data = ed; v.exp_id = eid;
    vecs.push_back(v);
  endtask

  // One clock: drive at negedge, check readys against the model, check outputs after posedge.
  task automatic cycle(input vec_t v);
    logic can, g, accept, rst_edge;
    rsp_t r;
    @(negedge clk);
    reset = v.rst; rsp_ready = v.rr;
    req0_valid = v.v0; req0_data = v.d0; req0_amt = v.a0; req0_lr = v.l0;
    req1_valid = v.v1; req1_data = v.d1; req1_amt = v.a1; req1_lr = v.l1;
    #1;
    can = !v.rst && (!m_hold || v.rr);
    g   = (v.v0 && v.v1) ? m_ptr : (v.v1 && !v.v0);
    check("req0_ready", {7'b0, req0_ready}, {7'b0, can && !g});
    check("req1_ready", {7'b0, req1_ready}, {7'b0, can && g});
    rst_edge = v.rst;
    if (v.rst) begin
      sb.delete();
      m_hold = 1'b0;
      m_ptr  = 1'b0;
    end else begin
      if (m_hold && v.rr) begin
        void'(sb.pop_front());
        m_hold = 1'b0;
      end
      accept = can && (g ? v.v1 : v.v0);
      if (accept) begin
        r.data = g ? ref_rot(v.d1, v.a1, v.l1) : ref_rot(v.d0, v.a0, v.l0);
        r.id   = g;
        sb.push_back(r);
        m_hold = 1'b1;
        m_ptr  = !g;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_valid", {7'b0, rsp_valid}, {7'b0, m_hold});
    if (m_hold && sb.size() > 0) begin
      check("sb_rsp_data", rsp_data, sb[0].data);
      check("sb_rsp_id", {7'b0, rsp_id}, {7'b0, sb[0].id});
    end
    if (rst_edge) begin
      check("reset_rsp_data", rsp_data, '0);
      check("reset_rsp_id", {7'b0, rsp_id}, 8'h00);
    end
    if (v.chk) begin
      check("tbl_rsp_valid", {7'b0, rsp_valid}, {7'b0, v.exp_valid});
      if (v.exp_valid) begin
        check("tbl_rsp_data", rsp_data, v.exp_data);
        check("tbl_rsp_id", {7'b0, rsp_id}, {7'b0, v.exp_id});
      end
    end
  endtask

  function automatic vec_t idle_vec(input logic rr);
    vec_t v;
    v = '{rst:1'b0, v0:1'b0, d0:'0, a0:'0, l0:1'b0, v1:1'b0, d1:'0, a1:'0, l1:1'b0,
          rr:rr, chk:1'b0, exp_valid:1'b0, exp_data:'0, exp_id:1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_lr = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_lr = 1'b0;

    //  rst v0 d0           a0 l0 v1 d1           a1 l1 rr chk ev ed           id
    add(1, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 0, 1, 0, 8'h00,        0);
    add(0, 1, 8'b01010110,  3, 1, 0, 8'h00,        0, 0, 1, 1, 1, 8'b10110010,  0);
    add(0, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 1, 1, 0, 8'h00,        0);
    add(0, 0, 8'h00,        0, 0, 1, 8'b01010110,  3, 0, 1, 1, 1, 8'b11001010,  1);
    add(0, 0, 8'h00,        0, 0, 1, 8'b01110101,  0, 0, 1, 1, 1, 8'b01110101,  1);
    add(0, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 1, 1, 0, 8'h00,        0);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b01111000,  0);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b11100001,  1);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b01111000,  0);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b11100001,  1);
    add(0, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 1, 1, 0, 8'h00,        0);
    // backpressure: three stalled cycles with req1 pending, then accepted on release
    add(0, 1, 8'b00111100,  2, 1, 0, 8'h00,        0, 0, 0, 1, 1, 8'b11110000,  0);
    add(0, 0, 8'h00,        0, 0, 1, 8'b10000001,  1, 0, 0, 1, 1, 8'b11110000,  0);
    add(0, 0, 8'h00,        0, 0, 1, 8'b10000001,  1, 0, 0, 1, 1, 8'b11110000,  0);
    add(0, 0, 8'h00,        0, 0, 1, 8'b10000001,  1, 0, 0, 1, 1, 8'b11110000,  0);
    add(0, 0, 8'h00,        0, 0, 1, 8'b10000001,  1, 0, 1, 1, 1, 8'b11000000,  1);
    add(0, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 1, 1, 0, 8'h00,        0);
    // reset while holding, then first contention must favour req0
    add(0, 1, 8'b00001111,  4, 1, 0, 8'h00,        0, 0, 0, 1, 1, 8'b11110000,  0);
    add(1, 0, 8'h00,        0, 0, 1, 8'b10101010,  1, 1, 0, 1, 0, 8'h00,        0);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b01111000,  0);
    add(0, 1, 8'b11110000,  1, 0, 1, 8'b11110000,  1, 1, 1, 1, 1, 8'b11100001,  1);
    add(0, 0, 8'h00,        0, 0, 0, 8'h00,        0, 0, 1, 1, 0, 8'h00,        0);

    foreach (vecs[i]) cycle(vecs[i]);

    // A requester that withdraws valid while stalled is never served.
    v = idle_vec(1'b0);
    v.v0 = 1'b1; v.d0 = 8'b10010011; v.a0 = 3'd5; v.l0 = 1'b0;
    cycle(v);
    v = idle_vec(1'b0);
    v.v1 = 1'b1; v.d1 = 8'b11000011; v.a1 = 3'd2; v.l1 = 1'b1;
    cycle(v);
    cycle(idle_vec(1'b1));
    cycle(idle_vec(1'b1));
    check("withdrawn_not_served", {7'b0, rsp_valid}, 8'h00);

    // Random traffic against the scoreboard model.
    for (int i = 0; i < 60; i++) begin
      v = idle_vec(1'($urandom_range(0, 3) != 0));
      v.v0 = 1'($urandom_range(0, 1)); v.d0 = W'($urandom); v.a0 = N'($urandom); v.l0 = 1'($urandom);
      v.v1 = 1'($urandom_range(0, 1)); v.d1 = W'($urandom); v.a1 = N'($urandom); v.l1 = 1'($urandom);
      v.rst = (i == 37);
      cycle(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_arbiter.md
ROTATE_ARBITER -- requirements
Module: rotate_arbiter

Interface
REQ-001 SHALL have parameter: N, default 3, log2 of data width; W = 2**N.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid  input  1 / req0_ready  output  1  requester 0 handshake.
REQ-005 SHALL have ports: req0_data  input  W / req0_amt  input  N / req0_lr  input  1  requester 0 operand, rotate amount, direction.
REQ-006 SHALL have ports: req1_valid, req1_ready, req1_data, req1_amt, req1_lr; same widths and meanings, requester 1.
REQ-007 SHALL have ports: rsp_valid  output  1 / rsp_ready  input  1  result handshake.
REQ-008 SHALL have ports: rsp_data  output  W  rotated result / rsp_id  output  1  index of the served requester.

Function
REQ-009 SHALL contain one shared rotator; lr=1 rotates left by amt, lr=0 rotates right by amt; bits wrap around; amt=0 passes data unchanged.
REQ-010 SHALL implement FSM with states IDLE (no result held) and HOLD (result registered, rsp_valid=1).
REQ-011 SHALL assert reqX_ready only for the granted requester, and only when state is IDLE, or state is HOLD with rsp_ready=1 in the same cycle.
REQ-012 SHALL complete a transfer when reqX_valid and reqX_ready are both 1; on transfer, it registers the rotated result and rsp_id and enters/stays in HOLD.
REQ-013 SHALL produce rsp_valid exactly one cycle after the accepting edge (latency 1); rsp_data is registered, not combinational.
REQ-014 SHALL hold rsp_valid, rsp_data and rsp_id stable in HOLD until rsp_ready=1.
REQ-015 SHALL go HOLD -> IDLE on rsp_ready=1 with no request valid, and HOLD -> HOLD with new data on rsp_ready=1 plus a valid request (back-to-back, one result per cycle).
REQ-016 SHALL grant the only valid requester when exactly one is valid.
REQ-017 SHALL grant, when both are valid, the requester not served by the last completed transfer (round-robin).
REQ-018 SHALL update the round-robin pointer only on a completed transfer, never on valid alone.
REQ-019 SHALL give priority to requester 0 on the first contention after reset.
REQ-020 SHALL keep both readys at 0 in HOLD while rsp_ready=0; a requester that drops valid before transfer is not served.

Reset
REQ-021 SHALL, when reset=1 at a clock edge, force IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, and the pointer to favour requester 0.
REQ-022 SHALL drop any held result on reset mid-operation; no transfer is accepted in a cycle where reset=1 (readys forced 0).

Structure
REQ-023 SHALL place the FSM state enum (IDLE, HOLD) in a shared package, rotate_pkg.
REQ-024 SHALL instantiate the existing combinational multi_barrel_shifter_reverser (parameter N; ports a, amt, lr, y) as its single sub-module, fed from the granted requester's mux.

Verification (N=3)
REQ-025 SHALL check single left rotate: req0 data=8'b01010110, amt=3, lr=1 -> next cycle rsp_valid=1, rsp_data=8'b10110010, rsp_id=0.
REQ-026 SHALL check single right rotate: req1 data=8'b01010110, amt=3, lr=0 -> rsp_data=8'b11001010, rsp_id=1; amt=0 on data 8'b01110101 -> 8'b01110101.
REQ-027 SHALL check contention: both valid continuously with rsp_ready=1 (req0 8'b11110000 amt1 lr0; req1 8'b11110000 amt1 lr1) -> grants alternate 0,1,0,1; rsp_data alternates 8'b01111000, 8'b11100001 on consecutive cycles.
REQ-028 SHALL check backpressure: rsp_ready=0 for 3 cycles while holding a result -> rsp_data/rsp_id stable, both readys 0; rsp_ready=1 -> pending request accepted same cycle.
REQ-029 SHALL check reset mid-operation: assert reset in HOLD -> next edge rsp_valid=0, rsp_data=0; first contention afterward grants req0.
